// File: rtl/timer_pkg.sv
// Shared types and bit positions for the bus_timer register window.
package timer_pkg;

    typedef enum logic [1:0] {
        CTRL   = 2'd0,
        LOAD   = 2'd1,
        COUNT  = 2'd2,
        STATUS = 2'd3
    } timer_reg_e;

    typedef struct packed {
        logic [7:0] psc;
        logic       ie;
        logic       ar;
        logic       en;
    } timer_ctrl_t;

    localparam int CTRL_EN_BIT        = 0;
    localparam int CTRL_AR_BIT        = 1;
    localparam int CTRL_IE_BIT        = 2;
    localparam int CTRL_PSC_LSB       = 8;
    localparam int STATUS_PENDING_BIT = 0;

    // CTRL as it appears on the bus: unused bits read back as zero.
    function automatic logic [31:0] ctrl_word(input timer_ctrl_t c);
        return {16'h0000, c.psc, 5'b00000, c.ie, c.ar, c.en};
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock down to one tick every psc+1 clocks while enabled.
module timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] psc,
    output logic       tick
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= 8'd0;
        else if (clear || !en)
            cnt <= 8'd0;
        else if (cnt == psc)
            cnt <= 8'd0;
        else
            cnt <= cnt + 8'd1;
    end

    // A restart leaves cnt at 0, so psc=0 ticks on every enabled clock.
    assign tick = en && (cnt == psc);

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer with sticky interrupt on the CPU bus.
// Optional prescaler is built when BUS_TIMER_PRESCALER_EN is defined.
module bus_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output tri   [31:0] data_out,
    input  logic        mem_rd,
    input  logic        mem_wr,
    output logic        hwint
);

    timer_ctrl_t ctrl;
    logic [31:0] load;
    logic [31:0] count;
    logic        pending;

    logic        sel;
    logic [1:0]  off;
    timer_reg_e  reg_sel;
    logic        wr_ctrl, wr_load, wr_count, wr_status;
    logic        tick;
    logic        expire;
    logic [31:0] rd_data;

    assign sel     = (addr >= BASE) && (addr <= BASE + 32'd3);
    assign off     = addr[1:0] - BASE[1:0];
    assign reg_sel = timer_reg_e'(off);

    assign wr_ctrl   = sel && mem_wr && (reg_sel == CTRL);
    assign wr_load   = sel && mem_wr && (reg_sel == LOAD);
    assign wr_count  = sel && mem_wr && (reg_sel == COUNT);
    assign wr_status = sel && mem_wr && (reg_sel == STATUS);

`ifdef BUS_TIMER_PRESCALER_EN
    timer_prescaler u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (wr_ctrl || wr_count),
        .en    (ctrl.en),
        .psc   (ctrl.psc),
        .tick  (tick)
    );
`else
    assign tick = ctrl.en;
`endif

    // A COUNT write pre-empts the whole countdown step, expiry included.
    assign expire = tick && (count == 32'd0) && !wr_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl    <= '0;
            load    <= 32'd0;
            count   <= 32'd0;
            pending <= 1'b0;
        end else begin
            if (tick && !wr_count) begin
                if (count != 32'd0)
                    count <= count - 32'd1;
                else if (ctrl.ar)
                    count <= load;
                else
                    ctrl.en <= 1'b0;
            end

            if (expire)
                pending <= 1'b1;
            else if (wr_status && data_in[STATUS_PENDING_BIT])
                pending <= 1'b0;

            // Software writes land last so they win over hardware updates.
            if (wr_ctrl) begin
                ctrl.en <= data_in[CTRL_EN_BIT];
                ctrl.ar <= data_in[CTRL_AR_BIT];
                ctrl.ie <= data_in[CTRL_IE_BIT];
`ifdef BUS_TIMER_PRESCALER_EN
                ctrl.psc <= data_in[CTRL_PSC_LSB +: 8];
`endif
            end
            if (wr_load)
                load <= data_in;
            if (wr_count)
                count <= data_in;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (reg_sel)
            CTRL:    rd_data = ctrl_word(ctrl);
            LOAD:    rd_data = load;
            COUNT:   rd_data = count;
            STATUS:  rd_data = {31'd0, pending};
            default: rd_data = 32'd0;
        endcase
    end

    assign data_out = (sel && mem_rd && !rst) ? rd_data : 32'bz;
    assign hwint    = pending && ctrl.ie;

endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: directed test-plan sequences then random traffic.
module tb_bus_timer;

    localparam logic [31:0] BASE   = 32'h0000_FF00;
    localparam logic [31:0] BUS_HI = 32'hFFFF_FFFF;
`ifdef BUS_TIMER_PRESCALER_EN
    localparam bit HAS_PSC = 1'b1;
`else
    localparam bit HAS_PSC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] data_in = 32'd0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    wire  [31:0] data_out;
    logic        hwint;

    // An undriven bus floats high so high-Z is observable as all ones.
    pullup (data_out);

    bus_timer #(.BASE(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .hwint    (hwint)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        hw;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: plain register contents plus clocks since prescale restart.
    logic        m_en, m_ar, m_ie, m_pend;
    logic [7:0]  m_psc;
    logic [31:0] m_load, m_count;
    int unsigned m_elapsed;

    logic        p_rst = 1'b1;
    logic [31:0] p_addr = 32'd0;
    logic [31:0] p_din = 32'd0;
    logic        p_rd = 1'b0;
    logic        p_wr = 1'b0;

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd3);
    endfunction

    task automatic model_reset();
        m_en = 1'b0; m_ar = 1'b0; m_ie = 1'b0; m_pend = 1'b0;
        m_psc = 8'd0; m_load = 32'd0; m_count = 32'd0; m_elapsed = 0;
    endtask

    task automatic model_step();
        logic [31:0] off;
        bit          wsel, tick, expire, restart;
        bit          w_ctl, w_ld, w_cnt, w_st;
        int unsigned period;
        if (p_rst) begin
            model_reset();
            return;
        end
        off    = p_addr - BASE;
        wsel   = in_win(p_addr) && p_wr;
        w_ctl  = wsel && (off == 32'd0);
        w_ld   = wsel && (off == 32'd1);
        w_cnt  = wsel && (off == 32'd2);
        w_st   = wsel && (off == 32'd3);
        period = int'(m_psc) + 1;
        tick   = m_en && ((m_elapsed % period) == period - 1);
        expire = tick && (m_count == 32'd0) && !w_cnt;
        restart = w_ctl || w_cnt || !m_en;
        if (tick && !w_cnt) begin
            if (m_count != 32'd0) m_count = m_count - 32'd1;
            else if (m_ar)        m_count = m_load;
            else                  m_en = 1'b0;
        end
        if (expire) m_pend = 1'b1;
        else if (w_st && p_din[0]) m_pend = 1'b0;
        if (w_ctl) begin
            m_en = p_din[0];
            m_ar = p_din[1];
            m_ie = p_din[2];
            if (HAS_PSC) m_psc = p_din[15:8];
        end
        if (w_ld)  m_load = p_din;
        if (w_cnt) m_count = p_din;
        m_elapsed = restart ? 0 : m_elapsed + 1;
    endtask

    function automatic exp_t model_expect();
        exp_t        e;
        logic [31:0] off;
        off    = addr - BASE;
        e.hw   = m_pend && m_ie;
        e.data = BUS_HI;
        if (!rst && mem_rd && in_win(addr)) begin
            case (off)
                32'd0:   e.data = {16'd0, m_psc, 5'd0, m_ie, m_ar, m_en};
                32'd1:   e.data = m_load;
                32'd2:   e.data = m_count;
                default: e.data = {31'd0, m_pend};
            endcase
        end
        return e;
    endfunction

    // One bus cycle: retire the previous cycle into the model, then drive the next.
    task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic rd, input logic wr);
        @(posedge clk);
        model_step();
        #1;
        rst = r; addr = a; data_in = d; mem_rd = rd; mem_wr = wr;
        p_rst = r; p_addr = a; p_din = d; p_rd = rd; p_wr = wr;
        if (r) model_reset();
        sb.push_back(model_expect());
    endtask

    task automatic wr_reg(input int o, input logic [31:0] d);
        cyc(1'b0, BASE + 32'(o), d, 1'b0, 1'b1);
    endtask

    task automatic rd_reg(input int o);
        cyc(1'b0, BASE + 32'(o), 32'd0, 1'b1, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (data_out !== e.data) begin
                    n_bad++;
                    $display("FAIL data_out @%0t addr=%h rd=%0b: got %h want %h",
                             $time, addr, mem_rd, data_out, e.data);
                end
                n_cmp++;
                if (hwint !== e.hw) begin
                    n_bad++;
                    $display("FAIL hwint @%0t: got %0b want %0b", $time, hwint, e.hw);
                end
            end
        end
    end

    initial begin : stim
        int o;
        logic [31:0] d;
        model_reset();

        // Reset state, including a read attempted while reset is held.
        cyc(1'b1, BASE + 32'd2, 32'd0, 1'b1, 1'b0);
        cyc(1'b1, BASE, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) rd_reg(i);

        // One-shot countdown from 3 with interrupt enabled.
        wr_reg(2, 32'd3);
        wr_reg(0, 32'h5);
        repeat (5) rd_reg(2);
        rd_reg(3); rd_reg(0); rd_reg(2);
        wr_reg(3, 32'd1);
        rd_reg(3);

        // Auto-reload period 3; STATUS clears land on and off expiry edges.
        wr_reg(0, 32'd0);
        wr_reg(1, 32'd2);
        wr_reg(2, 32'd2);
        wr_reg(0, 32'h7);
        repeat (7) rd_reg(3);
        repeat (6) wr_reg(3, 32'd1);
        rd_reg(3);
        wr_reg(0, 32'd0);

        // Decode edges and simultaneous read+write of LOAD.
        cyc(1'b0, BASE + 32'd4, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, BASE - 32'd1, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, BASE + 32'd4, 32'h0000_0007, 1'b0, 1'b1);
        cyc(1'b0, BASE - 32'd1, 32'h0000_1234, 1'b0, 1'b1);
        rd_reg(0); rd_reg(1);
        cyc(1'b0, BASE + 32'd1, 32'hABCD_0123, 1'b1, 1'b1);
        rd_reg(1);

        // COUNT write on the reload edge wins and does not raise pending.
        wr_reg(1, 32'd9);
        wr_reg(3, 32'd1);
        wr_reg(2, 32'd2);
        wr_reg(0, 32'h3);
        rd_reg(2); rd_reg(2);
        wr_reg(2, 32'd50);
        rd_reg(2); rd_reg(3);
        wr_reg(0, 32'd0);

        // psc field: live with the prescaler, read as zero without it.
        wr_reg(0, 32'h0000_0305);
        rd_reg(0);
        wr_reg(0, 32'd0);
        wr_reg(3, 32'd1);
        wr_reg(2, 32'd1);
        wr_reg(0, 32'h0000_0305);
        repeat (10) rd_reg(2);
        rd_reg(3); rd_reg(0);

        // Reset asserted mid-count, between edges.
        wr_reg(2, 32'd100);
        wr_reg(0, 32'h5);
        repeat (3) rd_reg(2);
        cyc(1'b1, BASE + 32'd2, 32'd0, 1'b1, 1'b0);
        cyc(1'b1, BASE + 32'd3, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) rd_reg(i);

        // Random traffic around the window.
        for (int n = 0; n < 800; n++) begin
            o = int'($urandom_range(0, 5)) - 1;
            case (o)
                0:       d = ($urandom_range(0, 3) << 8) | $urandom_range(0, 7);
                1, 2:    d = $urandom_range(0, 6);
                default: d = $urandom;
            endcase
            cyc(($urandom_range(0, 199) == 0), BASE + 32'(o), d,
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end
        cyc(1'b0, BASE, 32'd0, 1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
